// File: rtl/ula_arbitro.sv
`default_nettype none
// ============================================================================
//  Module   : ula_arbitro
//  Purpose  : Two-requester arbiter in front of a 6-bit ULA. It captures the
//             winning request, drives the ULA for one cycle, latches the
//             result and holds it on a valid/ready response port.
//  Revision : 1.0 - initial release
// ============================================================================
module ula_arbitro #(
    parameter int LARGURA = 6   // must match the ULA datapath width (6 only)
) (
    input  logic               clk,
    input  logic               reset,
    // requester 0
    input  logic               req0,
    input  logic [LARGURA-1:0] a0,
    input  logic [LARGURA-1:0] b0,
    input  logic [2:0]         op_sel0,
    input  logic               modo0,
    // requester 1
    input  logic               req1,
    input  logic [LARGURA-1:0] a1,
    input  logic [LARGURA-1:0] b1,
    input  logic [2:0]         op_sel1,
    input  logic               modo1,
    // grants
    output logic               gnt0,
    output logic               gnt1,
    // ULA side
    output logic [LARGURA-1:0] ula_A,
    output logic [LARGURA-1:0] ula_B,
    output logic [2:0]         ula_op_sel,
    output logic               ula_modo,
    output logic               ula_reset,
    input  logic [LARGURA-1:0] ula_O,
    input  logic               ula_zero,
    // response port
    output logic               resp_valid,
    output logic               resp_id,
    output logic [LARGURA-1:0] resp_O,
    output logic               resp_zero,
    input  logic               resp_ready,
    // status
    output logic               ocupado,
    output logic [7:0]         cont_ops
);

    typedef enum logic [1:0] {
        LIVRE = 2'd0,
        EXEC  = 2'd1,
        RESP  = 2'd2
    } estado_t;

    estado_t            r_estado;
    estado_t            w_estado_prox;

    logic               r_ptr;        // requester favoured when both ask
    logic               r_id;         // owner of the current transaction
    logic [LARGURA-1:0] r_a;
    logic [LARGURA-1:0] r_b;
    logic [2:0]         r_op;
    logic               r_modo;
    logic [LARGURA-1:0] r_resp_O;
    logic               r_resp_zero;
    logic [7:0]         r_cont;

    logic               w_tem_req;
    logic               w_vencedor;
    logic               w_aceita;
    logic               w_handshake;

    assign w_tem_req   = req0 | req1;
    // A lone request wins outright; a tie goes to the priority pointer.
    assign w_vencedor  = (req0 & req1) ? r_ptr : req1;
    assign w_aceita    = (r_estado == LIVRE) && w_tem_req;
    assign w_handshake = (r_estado == RESP) && resp_ready;

    // State register, cleared asynchronously so reset takes effect without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= LIVRE;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Next-state logic and all state-decoded outputs (ULA held in reset outside EXEC).
    always_comb begin
        w_estado_prox = r_estado;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        ula_A         = '0;
        ula_B         = '0;
        ula_op_sel    = 3'd0;
        ula_modo      = 1'b0;
        ula_reset     = 1'b1;
        resp_valid    = 1'b0;
        ocupado       = 1'b1;
        case (r_estado)
            LIVRE: begin
                ocupado = 1'b0;
                if (w_tem_req) begin
                    w_estado_prox = EXEC;
                end
            end
            EXEC: begin
                gnt0          = ~r_id;
                gnt1          = r_id;
                ula_reset     = 1'b0;
                ula_A         = r_a;
                ula_B         = r_b;
                ula_op_sel    = r_op;
                ula_modo      = r_modo;
                w_estado_prox = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_estado_prox = LIVRE;
                end
            end
            default: begin
                w_estado_prox = LIVRE;
            end
        endcase
    end

    // Datapath: operand capture on acceptance, result capture at the end of
    // EXEC, pointer flip and completion count on the response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 3'd0;
            r_modo      <= 1'b0;
            r_resp_O    <= '0;
            r_resp_zero <= 1'b0;
            r_cont      <= 8'd0;
        end else begin
            if (w_aceita) begin
                r_id   <= w_vencedor;
                r_a    <= w_vencedor ? a1 : a0;
                r_b    <= w_vencedor ? b1 : b0;
                r_op   <= w_vencedor ? op_sel1 : op_sel0;
                r_modo <= w_vencedor ? modo1 : modo0;
            end
            if (r_estado == EXEC) begin
                r_resp_O    <= ula_O;
                r_resp_zero <= ula_zero;
            end
            if (w_handshake) begin
                r_ptr  <= ~r_id;
                r_cont <= r_cont + 8'd1;
            end
        end
    end

    assign resp_id   = r_id;
    assign resp_O    = r_resp_O;
    assign resp_zero = r_resp_zero;
    assign cont_ops  = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_ula_arbitro.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_arbitro
//  Purpose  : Directed self-checking bench for ula_arbitro with a behavioural
//             ULA and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_arbitro;

    localparam int L = 6;

    logic         clk;
    logic         reset;
    logic         req0, req1;
    logic [L-1:0] a0, b0, a1, b1;
    logic [2:0]   op_sel0, op_sel1;
    logic         modo0, modo1;
    logic         gnt0, gnt1;
    logic [L-1:0] ula_A, ula_B;
    logic [2:0]   ula_op_sel;
    logic         ula_modo, ula_reset;
    logic [L-1:0] ula_O;
    logic         ula_zero;
    logic         resp_valid, resp_id;
    logic [L-1:0] resp_O;
    logic         resp_zero, resp_ready;
    logic         ocupado;
    logic [7:0]   cont_ops;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic         id;
        logic [L-1:0] o;
        logic         z;
    } exp_t;

    exp_t sb[$];

    ula_arbitro #(.LARGURA(L)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .op_sel0(op_sel0), .modo0(modo0),
        .req1(req1), .a1(a1), .b1(b1), .op_sel1(op_sel1), .modo1(modo1),
        .gnt0(gnt0), .gnt1(gnt1),
        .ula_A(ula_A), .ula_B(ula_B), .ula_op_sel(ula_op_sel),
        .ula_modo(ula_modo), .ula_reset(ula_reset),
        .ula_O(ula_O), .ula_zero(ula_zero),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_O(resp_O),
        .resp_zero(resp_zero), .resp_ready(resp_ready),
        .ocupado(ocupado), .cont_ops(cont_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA: logic ops only in modo=1; arithmetic mode and unused codes give 0.
    function automatic logic [L:0] ula_f(input logic [L-1:0] a, input logic [L-1:0] b,
                                         input logic [2:0] op, input logic m);
        logic [L-1:0] o;
        o = '0;
        if (m) begin
            case (op)
                3'b000:  o = a & b;
                3'b001:  o = a | b;
                3'b010:  o = a ^ b;
                3'b011:  o = ~a;
                3'b100:  o = ~(a & b);
                3'b101:  o = ~(a | b);
                default: o = '0;
            endcase
        end
        return {(o == '0), o};
    endfunction

    assign {ula_zero, ula_O} = ula_reset ? {1'b1, {L{1'b0}}}
                                         : ula_f(ula_A, ula_B, ula_op_sel, ula_modo);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_gnt0"}, gnt0, 0);
        chk({pfx, "_gnt1"}, gnt1, 0);
        chk({pfx, "_resp_valid"}, resp_valid, 0);
        chk({pfx, "_resp_id"}, resp_id, 0);
        chk({pfx, "_resp_O"}, resp_O, 0);
        chk({pfx, "_resp_zero"}, resp_zero, 0);
        chk({pfx, "_ula_reset"}, ula_reset, 1);
        chk({pfx, "_ula_AB"}, {ula_A, ula_B}, 0);
        chk({pfx, "_ula_op_modo"}, {ula_op_sel, ula_modo}, 0);
        chk({pfx, "_ocupado"}, ocupado, 0);
        chk({pfx, "_cont_ops"}, cont_ops, 0);
    endtask

    task automatic wait_grant(output logic g);
        int n;
        n = 0;
        while (!(gnt0 | gnt1) && n < 12) begin
            nxt();
            n++;
        end
        checks++;
        assert (gnt0 | gnt1) else begin
            errors++;
            $error("FAIL grant_timeout: observed no gnt after %0d cycles expected a gnt", n);
        end
        g = gnt1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ocupado && n < 20) begin
            nxt();
            n++;
        end
        chk("idle_timeout", ocupado, 0);
    endtask

    task automatic push_exp(input logic id, input logic [L-1:0] a, input logic [L-1:0] b,
                            input logic [2:0] op, input logic m);
        logic [L:0] r;
        r = ula_f(a, b, op, m);
        sb.push_back('{id: id, o: r[L-1:0], z: r[L]});
    endtask

    task automatic run_single(input logic id, input logic [L-1:0] a, input logic [L-1:0] b,
                              input logic [2:0] op, input logic m);
        logic g;
        if (id) begin
            req1 = 1'b1; a1 = a; b1 = b; op_sel1 = op; modo1 = m;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; op_sel0 = op; modo0 = m;
        end
        push_exp(id, a, b, op, m);
        wait_grant(g);
        chk("single_grant_id", g, id);
        chk("single_ula_AB", {ula_A, ula_B}, {a, b});
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();
    endtask

    // Scoreboard: pop and compare each response on its handshake cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_exclusive", gnt0 & gnt1, 0);
            if (resp_valid && resp_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_resp: observed queue size %0d expected >0", sb.size());
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_O", resp_O, e.o);
                    chk("resp_zero", resp_zero, e.z);
                    exp_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g;
        reset = 1'b1; resp_ready = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        op_sel0 = 3'd0; op_sel1 = 3'd0; modo0 = 1'b0; modo1 = 1'b0;
        #1;
        chk_reset_outputs("rst0");
        nxt();
        nxt();

        // AND 3C & 0F, request presented the moment reset releases
        reset = 1'b0;
        req0 = 1'b1; a0 = 6'h3C; b0 = 6'h0F; op_sel0 = 3'b000; modo0 = 1'b1;
        sb.push_back('{id: 1'b0, o: 6'h0C, z: 1'b0});
        nxt();
        chk("t1_gnt", {gnt0, gnt1}, 2'b10);
        chk("t1_ula", {ula_reset, ula_A, ula_B, ula_op_sel, ula_modo},
            {1'b0, 6'h3C, 6'h0F, 3'b000, 1'b1});
        chk("t1_ocupado", ocupado, 1);
        req0 = 1'b0; a0 = 6'h3F; op_sel0 = 3'b001;
        nxt();
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp", {resp_id, resp_O, resp_zero}, {1'b0, 6'h0C, 1'b0});
        chk("t1_ula_idle", {ula_reset, ula_A, ula_B, gnt0}, {1'b1, 12'h000, 1'b0});
        nxt();
        chk("t1_cont", cont_ops, 1);
        chk("t1_idle", {ocupado, resp_valid}, 2'b00);

        // Simultaneous requests from a fresh reset, held: grants alternate 0,1,0,1
        reset = 1'b1; exp_cnt = 0;
        nxt();
        reset = 1'b0;
        req0 = 1'b1; a0 = 6'h2A; b0 = 6'h2A; op_sel0 = 3'b010; modo0 = 1'b1;
        req1 = 1'b1; a1 = 6'h2A; b1 = 6'h2A; op_sel1 = 3'b010; modo1 = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back('{id: i[0], o: 6'h00, z: 1'b1});
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            chk("alt_grant", g, i % 2);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            nxt();
        end
        wait_idle();
        chk("alt_cont", cont_ops, 4);

        // Pass-through of zero results and a couple of ordinary ops
        run_single(1'b1, 6'h3C, 6'h0F, 3'b000, 1'b0);
        run_single(1'b0, 6'h3F, 6'h15, 3'b110, 1'b1);
        run_single(1'b1, 6'h30, 6'h05, 3'b001, 1'b1);
        run_single(1'b0, 6'h2A, 6'h00, 3'b011, 1'b1);

        // Back-pressure: response held 5 cycles while requester 1 waits
        resp_ready = 1'b0;
        req0 = 1'b1; a0 = 6'h15; b0 = 6'h0F; op_sel0 = 3'b000; modo0 = 1'b1;
        push_exp(1'b0, 6'h15, 6'h0F, 3'b000, 1'b1);
        wait_grant(g);
        chk("bp_grant0", g, 0);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 6'h01; b1 = 6'h02; op_sel1 = 3'b001; modo1 = 1'b1;
        push_exp(1'b1, 6'h01, 6'h02, 3'b001, 1'b1);
        nxt();
        a0 = 6'h3F;
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp", {resp_valid, resp_id, resp_O, resp_zero}, {1'b1, 1'b0, 6'h05, 1'b0});
            chk("bp_nogrant", {gnt0, gnt1}, 2'b00);
            chk("bp_busy", {ula_reset, ocupado}, 2'b11);
            nxt();
        end
        resp_ready = 1'b1;
        nxt();
        chk("bp_livre", {ocupado, gnt1}, 2'b00);
        nxt();
        chk("bp_grant1", {gnt0, gnt1}, 2'b01);
        chk("bp_ula_A1", ula_A, 6'h01);
        req1 = 1'b0;
        wait_idle();
        chk("bp_cont", cont_ops, exp_cnt[7:0]);

        // Reset asserted in the middle of EXEC discards the transaction
        reset = 1'b1; exp_cnt = 0;
        nxt();
        reset = 1'b0;
        req0 = 1'b1; a0 = 6'h3C; b0 = 6'h0F; op_sel0 = 3'b000; modo0 = 1'b1;
        nxt();
        chk("mid_in_exec", gnt0, 1);
        reset = 1'b1;
        req0 = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        nxt();
        reset = 1'b0;
        nxt();
        nxt();
        chk("mid_after", {resp_valid, ocupado, cont_ops}, 10'd0);

        // 256 completions wrap the counter back to zero
        for (int i = 0; i < 256; i++) begin
            run_single(i[0], 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (i == 254) chk("cont_255", cont_ops, 255);
        end
        chk("cont_wrap", cont_ops, 0);
        chk("cont_model", cont_ops, exp_cnt[7:0]);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
